// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; operands registered onto the ALU,
// result and flags captured after ALU_LAT cycles and returned with the requester id.
module alu_arbiter #(
   parameter int DW      = 32,
   parameter int FNW     = 6,
   parameter int ALU_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic [FNW-1:0] req0_fn,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   input  logic [FNW-1:0] req1_fn,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [FNW-1:0] alu_fn,
   input  logic [DW-1:0]  alu_y,
   input  logic           alu_z,
   input  logic           alu_v,
   input  logic           alu_n,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [DW-1:0]  rsp_y,
   output logic           rsp_z,
   output logic           rsp_v,
   output logic           rsp_n
);

   localparam int            CW     = $clog2(ALU_LAT + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(ALU_LAT - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state, state_n;
   logic          rr_last;
   logic          cur_id;
   logic [CW-1:0] cnt;
   logic          grant0, grant1;
   logic          accept;

   // On a tie the requester that did not go last wins.
   assign grant0     = req0_valid & (~req1_valid | rr_last);
   assign grant1     = req1_valid & (~req0_valid | ~rr_last);
   assign req0_ready = (state == IDLE) & ~reset & grant0;
   assign req1_ready = (state == IDLE) & ~reset & grant1;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept)         state_n = EXEC;
         EXEC:    if (cnt == '0)      state_n = RESP;
         RESP:    if (rsp_ready)      state_n = IDLE;
         default:                     state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last   <= 1'b1;
         cur_id    <= 1'b0;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fn    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_y     <= '0;
         rsp_z     <= 1'b0;
         rsp_v     <= 1'b0;
         rsp_n     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a  <= req1_ready ? req1_a  : req0_a;
                  alu_b  <= req1_ready ? req1_b  : req0_b;
                  alu_fn <= req1_ready ? req1_fn : req0_fn;
                  cur_id <= req1_ready;
                  cnt    <= LAT_M1;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_y     <= alu_y;
                  rsp_z     <= alu_z;
                  rsp_v     <= alu_v;
                  rsp_n     <= alu_n;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_last   <= rsp_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
